grf_wb: RTL and testbench
=========================

Name: grf_wb

Overview:
- General register file at the tail of the 5-stage MIPS pipeline; it consumes the write-back address from the WB write-address mux (rd / rt / 31).
- Holds 32 x 32-bit registers with $0 hardwired to zero.
- Two asynchronous read ports serve the ID stage; one synchronous write port is driven from WB.
- Provides optional internal WB-to-ID bypass and a commit trace (counter plus last-write record) for the verification monitor.

Parameters:
BYPASS_EN, 1, 1 = a read of the register being written this cycle returns the write data; 0 = returns the stored value.
CNT_W, 32, width of the commit counter.
RST_PC, 32'h0000_3000, value loaded into last_pc on reset.

Ports:
clk  input  1  pipeline clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
RegWrite_WB  input  1  write enable from WB control.
MUX_WAout  input  5  write register number from the WB write-address mux.
WD_WB  input  32  write-back data.
PC_WB  input  32  PC of the instruction in WB.
A1  input  5  ID read address 1 (rs).
A2  input  5  ID read address 2 (rt).
RD1  output  32  read data 1.
RD2  output  32  read data 2.
commit_cnt  output  CNT_W  number of committed register writes.
last_valid  output  1  at least one write has committed since reset.
last_wa  output  5  register number of the most recent committed write.
last_wd  output  32  data of the most recent committed write.
last_pc  output  32  PC of the most recent committed write.

Behaviour:
- Reset (reset == 0) acts asynchronously, with no clock required:
  - all 32 registers clear to 0;
  - commit_cnt = 0, last_valid = 0, last_wa = 0, last_wd = 0, last_pc = RST_PC.
  - While reset is held, the read ports return 0 for every address: stored values are 0 and bypass is suppressed.
  - Assertion mid-operation wins over a same-edge write; that write is lost.
  - Deassertion is synchronised externally; the first write can commit on the first rising edge with reset == 1.
- Commit condition: commit = RegWrite_WB & (MUX_WAout != 0) & reset.
- On a rising clk edge with commit:
  - reg[MUX_WAout] <= WD_WB;
  - commit_cnt <= commit_cnt + 1, wrapping at 2^CNT_W - 1 -> 0;
  - last_valid <= 1, last_wa <= MUX_WAout, last_wd <= WD_WB, last_pc <= PC_WB.
- Write to $0 (RegWrite_WB = 1, MUX_WAout = 0): no state change, not counted, last_* unchanged.
- RegWrite_WB = 0: no state change, regardless of MUX_WAout or WD_WB values (including X).
- Reads are combinational, with zero latency. For each port n:
  - RDn = 0 if An == 0;
  - else WD_WB if BYPASS_EN & RegWrite_WB & reset & (MUX_WAout == An);
  - else reg[An].
- With A1 == A2, both ports return identical data, including the bypass case.
- Write-then-read timing: a write at edge k is visible from stored state immediately after edge k. With BYPASS_EN = 0, a same-cycle read returns the old value.
- No X propagation: RDn is never X for a known An once reset has been applied.
- Single write port: at most one commit per cycle.
- The register array holds all 32 entries; entry 0 is never written.

Test Plan:
- Reset: hold reset = 0 while driving RegWrite_WB = 1, MUX_WAout = 5, WD_WB = 32'hDEAD_BEEF, then release -> RD1 (A1 = 5) = 0, commit_cnt = 0, last_valid = 0, last_pc = 32'h0000_3000.
- Basic write/read: write $8 = 32'h1234_5678 at PC 32'h3004, then read A1 = 8 -> RD1 = 32'h1234_5678, commit_cnt = 1, last_wa = 8, last_wd = 32'h1234_5678, last_pc = 32'h3004, last_valid = 1.
- $0 protection: RegWrite_WB = 1, MUX_WAout = 0, WD_WB = 32'hFFFF_FFFF -> RD1 (A1 = 0) = 0, commit_cnt unchanged, last_* unchanged.
- Bypass: $9 holds 1, then in the same cycle RegWrite_WB = 1, MUX_WAout = 9, WD_WB = 7 and A1 = A2 = 9 -> RD1 = RD2 = 7 before the edge with BYPASS_EN = 1, or 1 with BYPASS_EN = 0; both return 7 after the edge.
- Jal-style $31 write: MUX_WAout = 31, WD_WB = 32'h0000_300C -> RD2 (A2 = 31) = 32'h0000_300C; with RegWrite_WB = 0 on the next cycle and WD_WB = 0, the value is retained.
- Async reset mid-stream: write 10 registers, then pulse reset low for 3 ns between edges -> all reads = 0 immediately and commit_cnt = 0; set CNT_W = 4 with 16 commits -> commit_cnt wraps to 0.

Source files
------------

// File: rtl/grf_wb.sv
// grf_wb: 32 x 32-bit MIPS general register file at the WB/ID boundary.
// One synchronous write port from WB, two combinational read ports for ID,
// optional WB-to-ID bypass, and a commit trace for the verification monitor.
module grf_wb #(
   parameter bit          BYPASS_EN = 1'b1,
   parameter int          CNT_W     = 32,
   parameter logic [31:0] RST_PC    = 32'h0000_3000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             RegWrite_WB,
   input  logic [4:0]       MUX_WAout,
   input  logic [31:0]      WD_WB,
   input  logic [31:0]      PC_WB,
   input  logic [4:0]       A1,
   input  logic [4:0]       A2,
   output logic [31:0]      RD1,
   output logic [31:0]      RD2,
   output logic [CNT_W-1:0] commit_cnt,
   output logic             last_valid,
   output logic [4:0]       last_wa,
   output logic [31:0]      last_wd,
   output logic [31:0]      last_pc
);

   logic [31:0]      r_regs [0:31];
   logic [CNT_W-1:0] r_commit_cnt;
   logic             r_last_valid;
   logic [4:0]       r_last_wa;
   logic [31:0]      r_last_wd;
   logic [31:0]      r_last_pc;

   logic             w_commit;
   logic             w_byp_live;
   logic             w_byp1;
   logic             w_byp2;

   // A write to $0 never commits, so entry 0 can never leave its reset value.
   assign w_commit   = RegWrite_WB & (MUX_WAout != 5'd0) & reset;

   // Bypass is only live outside reset so that reads stay zero while reset is held.
   assign w_byp_live = BYPASS_EN & RegWrite_WB & reset;
   assign w_byp1     = w_byp_live & (MUX_WAout == A1);
   assign w_byp2     = w_byp_live & (MUX_WAout == A2);

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_reg
         // Per-entry storage: cleared by reset, loaded when the commit targets this entry.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_regs[gi] <= 32'd0;
            end else if (w_commit && (MUX_WAout == 5'(gi))) begin
               r_regs[gi] <= WD_WB;
            end
         end
      end
   endgenerate

   // Commit trace: counter plus a record of the most recent committed write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_commit_cnt <= '0;
         r_last_valid <= 1'b0;
         r_last_wa    <= 5'd0;
         r_last_wd    <= 32'd0;
         r_last_pc    <= RST_PC;
      end else if (w_commit) begin
         r_commit_cnt <= r_commit_cnt + 1'b1;
         r_last_valid <= 1'b1;
         r_last_wa    <= MUX_WAout;
         r_last_wd    <= WD_WB;
         r_last_pc    <= PC_WB;
      end
   end

   // Zero-latency read ports: $0 first, then the in-flight write, then stored state.
   always_comb begin
      RD1 = 32'd0;
      RD2 = 32'd0;
      if (A1 != 5'd0) begin
         RD1 = w_byp1 ? WD_WB : r_regs[A1];
      end
      if (A2 != 5'd0) begin
         RD2 = w_byp2 ? WD_WB : r_regs[A2];
      end
   end

   assign commit_cnt = r_commit_cnt;
   assign last_valid = r_last_valid;
   assign last_wa    = r_last_wa;
   assign last_wd    = r_last_wd;
   assign last_pc    = r_last_pc;

endmodule

// File: tb/tb_grf_wb.sv
// tb_grf_wb: directed bench for grf_wb; a default instance (bypass on,
// 32-bit counter) and a second instance (bypass off, 4-bit counter) share stimulus.
module tb_grf_wb;

   logic        clk;
   logic        reset;
   logic        RegWrite_WB;
   logic [4:0]  MUX_WAout;
   logic [31:0] WD_WB;
   logic [31:0] PC_WB;
   logic [4:0]  A1;
   logic [4:0]  A2;

   logic [31:0] RD1_a, RD2_a, last_wd_a, last_pc_a;
   logic [31:0] cnt_a;
   logic        last_valid_a;
   logic [4:0]  last_wa_a;

   logic [31:0] RD1_b, RD2_b, last_wd_b, last_pc_b;
   logic [3:0]  cnt_b;
   logic        last_valid_b;
   logic [4:0]  last_wa_b;

   int n_checks = 0;
   int n_fail   = 0;

   grf_wb u_dut_a (
      .clk(clk), .reset(reset), .RegWrite_WB(RegWrite_WB), .MUX_WAout(MUX_WAout),
      .WD_WB(WD_WB), .PC_WB(PC_WB), .A1(A1), .A2(A2), .RD1(RD1_a), .RD2(RD2_a),
      .commit_cnt(cnt_a), .last_valid(last_valid_a), .last_wa(last_wa_a),
      .last_wd(last_wd_a), .last_pc(last_pc_a)
   );

   grf_wb #(.BYPASS_EN(1'b0), .CNT_W(4)) u_dut_b (
      .clk(clk), .reset(reset), .RegWrite_WB(RegWrite_WB), .MUX_WAout(MUX_WAout),
      .WD_WB(WD_WB), .PC_WB(PC_WB), .A1(A1), .A2(A2), .RD1(RD1_b), .RD2(RD2_b),
      .commit_cnt(cnt_b), .last_valid(last_valid_b), .last_wa(last_wa_b),
      .last_wd(last_wd_b), .last_pc(last_pc_b)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply one WB transaction at the falling edge (checks may follow before the rising edge).
   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [31:0] pc);
      @(negedge clk);
      RegWrite_WB = we;
      MUX_WAout   = wa;
      WD_WB       = wd;
      PC_WB       = pc;
      $display("[%0t] txn we=%0b wa=%0d wd=%h pc=%h", $time, we, wa, wd, pc);
   endtask

   // Let the rising edge happen, then sample 1 ns later with the write disabled.
   task automatic edge_then_idle();
      @(posedge clk);
      #1;
      RegWrite_WB = 1'b0;
   endtask

   initial begin
      reset = 1'b0; RegWrite_WB = 1'b1; MUX_WAout = 5'd5; WD_WB = 32'hDEAD_BEEF;
      PC_WB = 32'h0; A1 = 5'd5; A2 = 5'd5;

      // Reset held with a write pending: reads stay zero, nothing commits.
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_rd1_a", RD1_a, 32'd0);
      check("rst_hold_rd2_b", RD2_b, 32'd0);
      @(negedge clk);
      reset = 1'b1; RegWrite_WB = 1'b0;
      #1;
      check("rst_rd1_a",   RD1_a, 32'd0);
      check("rst_cnt_a",   cnt_a, 32'd0);
      check("rst_valid_a", {31'd0, last_valid_a}, 32'd0);
      check("rst_wa_a",    {27'd0, last_wa_a}, 32'd0);
      check("rst_wd_a",    last_wd_a, 32'd0);
      check("rst_pc_a",    last_pc_a, 32'h0000_3000);
      check("rst_cnt_b",   {28'd0, cnt_b}, 32'd0);

      // Basic write then read.
      A1 = 5'd8;
      drive(1'b1, 5'd8, 32'h1234_5678, 32'h0000_3004);
      edge_then_idle();
      check("wr8_rd1_a",   RD1_a, 32'h1234_5678);
      check("wr8_rd1_b",   RD1_b, 32'h1234_5678);
      check("wr8_cnt_a",   cnt_a, 32'd1);
      check("wr8_wa_a",    {27'd0, last_wa_a}, 32'd8);
      check("wr8_wd_a",    last_wd_a, 32'h1234_5678);
      check("wr8_pc_a",    last_pc_a, 32'h0000_3004);
      check("wr8_valid_a", {31'd0, last_valid_a}, 32'd1);

      // Write to $0 is ignored.
      A1 = 5'd0;
      drive(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_3008);
      #2;
      check("z0_pre_rd1_a", RD1_a, 32'd0);
      edge_then_idle();
      check("z0_rd1_a", RD1_a, 32'd0);
      check("z0_cnt_a", cnt_a, 32'd1);
      check("z0_wa_a",  {27'd0, last_wa_a}, 32'd8);
      check("z0_wd_a",  last_wd_a, 32'h1234_5678);
      check("z0_pc_a",  last_pc_a, 32'h0000_3004);

      // Bypass: $9 = 1, then rewrite $9 = 7 while reading it on both ports.
      drive(1'b1, 5'd9, 32'd1, 32'h0000_3008);
      edge_then_idle();
      A1 = 5'd9; A2 = 5'd9;
      drive(1'b1, 5'd9, 32'd7, 32'h0000_300C);
      #2;
      check("byp_pre_rd1_a", RD1_a, 32'd7);
      check("byp_pre_rd2_a", RD2_a, 32'd7);
      check("byp_pre_rd1_b", RD1_b, 32'd1);
      check("byp_pre_rd2_b", RD2_b, 32'd1);
      edge_then_idle();
      check("byp_post_rd1_a", RD1_a, 32'd7);
      check("byp_post_rd2_b", RD2_b, 32'd7);
      check("byp_cnt_a", cnt_a, 32'd3);

      // Disabled write with unknown data changes nothing.
      drive(1'b0, 5'd9, 32'hxxxx_xxxx, 32'h0000_3010);
      edge_then_idle();
      check("nowe_rd1_a", RD1_a, 32'd7);
      check("nowe_cnt_a", cnt_a, 32'd3);
      check("nowe_wd_a",  last_wd_a, 32'd7);

      // Jal-style $31 write, then retained across an idle cycle.
      A2 = 5'd31;
      drive(1'b1, 5'd31, 32'h0000_300C, 32'h0000_3014);
      edge_then_idle();
      check("jal_rd2_a", RD2_a, 32'h0000_300C);
      check("jal_wa_a",  {27'd0, last_wa_a}, 32'd31);
      drive(1'b0, 5'd31, 32'd0, 32'h0000_3018);
      edge_then_idle();
      check("jal_keep_rd2_a", RD2_a, 32'h0000_300C);
      check("jal_keep_rd2_b", RD2_b, 32'h0000_300C);
      check("jal_cnt_a", cnt_a, 32'd4);

      // Ten more writes: $1..$10 = i * 0x11.
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, 5'(i), 32'(i * 32'h11), 32'h0000_4000 + 32'(4 * i));
         edge_then_idle();
      end
      A1 = 5'd10; A2 = 5'd5;
      #1;
      check("ten_rd1_a", RD1_a, 32'h0000_00AA);
      check("ten_rd2_a", RD2_a, 32'h0000_0055);
      check("ten_cnt_a", cnt_a, 32'd14);
      check("ten_cnt_b", {28'd0, cnt_b}, 32'd14);

      // 3 ns reset pulse between edges clears everything immediately.
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("pulse_rd1_a",   RD1_a, 32'd0);
      check("pulse_rd2_a",   RD2_a, 32'd0);
      check("pulse_cnt_a",   cnt_a, 32'd0);
      check("pulse_valid_a", {31'd0, last_valid_a}, 32'd0);
      check("pulse_pc_a",    last_pc_a, 32'h0000_3000);
      #2;
      reset = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         A1 = 5'(i);
         #0.5;
         check($sformatf("pulse_clr_r%0d", i), RD1_a, 32'd0);
      end

      // Counter wrap on the 4-bit instance after 16 commits.
      for (int i = 0; i < 15; i++) begin
         drive(1'b1, 5'd3, 32'(i), 32'h0000_5000);
         edge_then_idle();
      end
      check("wrap15_cnt_b", {28'd0, cnt_b}, 32'd15);
      drive(1'b1, 5'd3, 32'h0000_00FF, 32'h0000_5004);
      edge_then_idle();
      check("wrap_cnt_b",  {28'd0, cnt_b}, 32'd0);
      check("wrap_cnt_a",  cnt_a, 32'd16);
      check("wrap_pc_b",   last_pc_b, 32'h0000_5004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
